uart_rx_fifo_param: RTL
=======================

Name: uart_rx_fifo_param

Overview:
Parametrised receive-data FIFO for the UART peripheral, next generation of the fixed 8x8 RX buffer. It sits between the UART receiver shift logic (write side) and the register/bus interface (read side). It adds configurable width and depth, a registered read handshake, a programmable fill-level interrupt, flush, and sticky overflow/underflow error flags.

Parameters:
DATA_W, 8, width of one received character in bits (5..9 legal)
DEPTH, 16, number of entries; power of two, >= 2
CNT_W, $clog2(DEPTH)+1, derived width of the occupancy count; not to be overridden

Ports:
clk_i  input  1  system clock; all state updates on rising edge
rst_i  input  1  synchronous reset, active-high
flush_i  input  1  synchronous FIFO clear; pointers and count to 0
wr_en_i  input  1  write request from the receiver, one character per cycle
data_i  input  DATA_W  character to write
rd_en_i  input  1  read request from the bus side
data_o  output  DATA_W  read data, registered
rd_valid_o  output  1  one-cycle pulse; data_o holds a newly read word
full_o  output  1  count == DEPTH
empty_o  output  1  count == 0
count_o  output  CNT_W  current occupancy, 0..DEPTH
thresh_i  input  CNT_W  fill-level interrupt threshold
intr_thresh_o  output  1  fill-level interrupt
overflow_o  output  1  sticky: write dropped because FIFO was full
underflow_o  output  1  sticky: read rejected because FIFO was empty
err_clr_i  input  1  clears overflow_o and underflow_o

Behaviour:
- Priority each cycle: rst_i > flush_i > normal operation.
- Reset state: wr_ptr, rd_ptr and count = 0; data_o = 0; rd_valid_o = 0; overflow_o = 0; underflow_o = 0. Storage array is not reset; its contents are unobservable until written.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count is held as a separate register, not derived from the pointers.
- Read acceptance: rd_acc = rd_en_i && !empty_o.
- Write acceptance: wr_acc = wr_en_i && (!full_o || rd_acc). A write while full is accepted if a read is accepted in the same cycle.
- Accepted write: mem[wr_ptr] <= data_i; wr_ptr increments.
- Accepted read: data_o <= mem[rd_ptr]; rd_ptr increments; rd_valid_o = 1 in the following cycle only. Read latency is 1 cycle.
- data_o holds its last value when no read is accepted.
- Count update:
  - count +1 on wr_acc only
  - count -1 on rd_acc only
  - count unchanged when both or neither are accepted
- Write while empty, with a read in the same cycle: the read is rejected. No bypass; the word becomes readable on the next cycle.
- Rejected write (wr_en_i while full, no accepted read): data dropped, no pointer or count change, overflow_o <= 1.
- Rejected read (rd_en_i while empty): underflow_o <= 1, rd_valid_o stays 0, data_o unchanged.
- err_clr_i clears both sticky flags. A new error in the same cycle wins (flag stays 1).
- flush_i behaviour:
  - pointers and count <= 0; rd_valid_o <= 0
  - any same-cycle read or write is ignored and raises no error flag
  - data_o and the error flags are unchanged
- full_o, empty_o and count_o are driven combinationally from registers only; no input-to-output combinational path.
- intr_thresh_o = (thresh_i != 0) && (count >= thresh_i). It is level, not sticky. thresh_i = 0 disables it; thresh_i > DEPTH never asserts. thresh_i may change at any time; the effect is immediate on the output.
- Reset asserted mid-stream: full reset state on the next edge regardless of other inputs.

Test Plan:
- Bench config DATA_W=8, DEPTH=4. Apply reset, then write 0x11,0x22,0x33,0x44 on consecutive cycles -> count_o = 4, full_o = 1, empty_o = 0. Then read 4 cycles -> data_o = 0x11..0x44, each 1 cycle after its rd_en_i, rd_valid_o high 4 cycles, ending empty_o = 1.
- Full FIFO, write 0x55 with no read -> overflow_o = 1, count_o stays 4. Read all -> 0x55 never appears. err_clr_i pulse -> overflow_o = 0.
- Full FIFO, simultaneous rd_en_i and wr_en_i with 0x66 -> count_o stays 4, data_o = head word, 0x66 becomes the last entry read.
- Empty FIFO, rd_en_i alone -> underflow_o = 1, rd_valid_o = 0. Then simultaneous write 0x77 and read -> count_o = 1, read rejected. Next-cycle read -> data_o = 0x77.
- thresh_i = 3, write 3 words -> intr_thresh_o rises the cycle count_o reaches 3. Read 1 -> intr_thresh_o deasserts. thresh_i = 0 -> intr_thresh_o stays 0 at every count.
- Write 10 words with interleaved reads to exercise pointer wrap -> output order matches input order. flush_i with 2 words stored -> count_o = 0, empty_o = 1, data_o unchanged. rst_i mid-stream -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/uart_rx_fifo_param.sv
// Parametrised UART receive FIFO with registered read port, fill-level interrupt,
// flush and sticky overflow/underflow flags.
module uart_rx_fifo_param #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              wr_en_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              rd_en_i,
   output logic [DATA_W-1:0] data_o,
   output logic              rd_valid_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [CNT_W-1:0]  count_o,
   input  logic [CNT_W-1:0]  thresh_i,
   output logic              intr_thresh_o,
   output logic              overflow_o,
   output logic              underflow_o,
   input  logic              err_clr_i
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              mem_we;
   logic              rd_acc;
   logic              wr_acc;

   assign full_o  = (count_q == DEPTH_C);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

   // A full FIFO still takes a write when a read frees a slot in the same cycle.
   assign rd_acc = rd_en_i && !empty_o;
   assign wr_acc = wr_en_i && (!full_o || rd_acc);

   assign data_o        = data_q;
   assign rd_valid_o    = rd_valid_q;
   assign overflow_o    = overflow_q;
   assign underflow_o   = underflow_q;
   assign intr_thresh_o = (thresh_i != '0) && (count_q >= thresh_i);

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      data_d      = data_q;
      rd_valid_d  = 1'b0;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      mem_we      = 1'b0;

      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         mem_we     = wr_acc;
         rd_valid_d = rd_acc;
         if (rd_acc) begin
            data_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
         // A fresh error in the clear cycle keeps its flag set.
         overflow_d  = (overflow_q && !err_clr_i) || (wr_en_i && !wr_acc);
         underflow_d = (underflow_q && !err_clr_i) || (rd_en_i && !rd_acc);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         data_q      <= '0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         data_q      <= data_d;
         rd_valid_q  <= rd_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (mem_we && !rst_i) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule
